// File: rtl/text_banner_draw_if.sv
// Pixel/control bundle between the VGA counter side and text_banner_draw.
interface text_banner_draw_if;
  logic       frame_tick;
  logic [9:0] start_x, start_y;
  logic [9:0] x, y;
  logic       wr_en;
  logic [3:0] wr_idx;
  logic [4:0] wr_code;
  logic       scroll_en, blink_en;
  logic       display;

  modport master (output frame_tick, start_x, start_y, x, y, wr_en, wr_idx, wr_code,
                         scroll_en, blink_en,
                  input  display);
  modport slave  (input  frame_tick, start_x, start_y, x, y, wr_en, wr_idx, wr_code,
                         scroll_en, blink_en,
                  output display);
endinterface

// File: rtl/text_banner_draw.sv
// Scrolling, blinking 5x7 text banner; x/y sampled at edge N -> display after edge N+2.
// Define TEXT_BANNER_BORDER_EN to also draw the 1-pixel outline of the text window.
module text_banner_draw #(
  parameter int NUM_CHARS    = 4,
  parameter int SCALE_LOG2   = 2,
  parameter int SCROLL_STEP  = 1,
  parameter int BLINK_FRAMES = 30
) (
  input logic clk,
  input logic rst_n,
  text_banner_draw_if.slave bus
);
  localparam int          CELL_W  = 6 << SCALE_LOG2;
  localparam int          CELL_H  = 7 << SCALE_LOG2;
  localparam logic [15:0] TW16    = 16'(NUM_CHARS * CELL_W);
  localparam logic [15:0] CH16    = 16'(CELL_H);
  localparam logic [15:0] STEP16  = 16'(SCROLL_STEP);
  localparam logic [15:0] BLAST   = 16'(BLINK_FRAMES - 1);
  localparam logic [4:0]  NC5     = 5'(NUM_CHARS);

  typedef struct packed {
    logic        in_win;
    logic        border;
    logic [15:0] rel_x;
    logic [15:0] rel_y;
  } s1_t;

  typedef struct packed {
    logic       in_win;
    logic       border;
    logic [4:0] code;
    logic [2:0] row;
    logic [2:0] col;
  } s2_t;

  // Row-major, MSB = top-left pixel.
  function automatic logic [34:0] font(input logic [4:0] c);
    case (c)
      5'd1:  font = 35'b01110_10001_10001_11111_10001_10001_10001;
      5'd2:  font = 35'b11110_10001_10001_11110_10001_10001_11110;
      5'd3:  font = 35'b01110_10001_10000_10000_10000_10001_01110;
      5'd4:  font = 35'b11100_10010_10001_10001_10001_10010_11100;
      5'd5:  font = 35'b11111_10000_10000_11110_10000_10000_11111;
      5'd6:  font = 35'b11111_10000_10000_11110_10000_10000_10000;
      5'd7:  font = 35'b01110_10001_10000_10111_10001_10001_01111;
      5'd8:  font = 35'b10001_10001_10001_11111_10001_10001_10001;
      5'd9:  font = 35'b01110_00100_00100_00100_00100_00100_01110;
      5'd10: font = 35'b00111_00010_00010_00010_00010_10010_01100;
      5'd11: font = 35'b10001_10010_10100_11000_10100_10010_10001;
      5'd12: font = 35'b10000_10000_10000_10000_10000_10000_11111;
      5'd13: font = 35'b10001_11011_10101_10101_10001_10001_10001;
      5'd14: font = 35'b10001_10001_11001_10101_10011_10001_10001;
      5'd15: font = 35'b01110_10001_10001_10001_10001_10001_01110;
      5'd16: font = 35'b11110_10001_10001_11110_10000_10000_10000;
      5'd17: font = 35'b01110_10001_10001_10001_10101_10010_01101;
      5'd18: font = 35'b11110_10001_10001_11110_10100_10010_10001;
      5'd19: font = 35'b01111_10000_10000_01110_00001_00001_11110;
      5'd20: font = 35'b11111_00100_00100_00100_00100_00100_00100;
      5'd21: font = 35'b10001_10001_10001_10001_10001_10001_01110;
      5'd22: font = 35'b10001_10001_10001_10001_10001_01010_00100;
      5'd23: font = 35'b10001_10001_10001_10101_10101_10101_01010;
      5'd24: font = 35'b10001_10001_01010_00100_01010_10001_10001;
      5'd25: font = 35'b10001_10001_01010_00100_00100_00100_00100;
      5'd26: font = 35'b11111_00001_00010_00100_01000_10000_11111;
      default: font = '0;
    endcase
  endfunction

  logic [15:0][4:0] slot;
  logic [15:0]      scroll_off, bcnt;
  logic             visible;
  logic [1:0]       vld_pipe;
  s1_t              s1;
  s2_t              s2;

  // Stage 1: window test by explicit compares (16-bit, so no 10-bit wrap).
  logic [15:0] x16, y16, sx16, sy16, dx, dy, sum, scroll_nxt;
  logic        in_win, edge_hit;
  assign x16    = {6'd0, bus.x};
  assign y16    = {6'd0, bus.y};
  assign sx16   = {6'd0, bus.start_x};
  assign sy16   = {6'd0, bus.start_y};
  assign dx     = x16 - sx16;
  assign dy     = y16 - sy16;
  assign sum    = dx + scroll_off;
  assign in_win = (x16 >= sx16) && (x16 < sx16 + TW16) && (y16 >= sy16) && (y16 < sy16 + CH16);

`ifdef TEXT_BANNER_BORDER_EN
  assign edge_hit = (dx == 16'd0) || (dx == TW16 - 16'd1) || (dy == 16'd0) || (dy == CH16 - 16'd1);
`else
  assign edge_hit = 1'b0;
`endif

  // Stage 2: character index via compare chain against cell boundaries.
  logic [3:0]  idx;
  logic [15:0] base, off;
  always_comb begin
    idx  = '0;
    base = '0;
    for (int i = 1; i < NUM_CHARS; i++)
      if (s1.rel_x >= 16'(i * CELL_W)) begin
        idx  = 4'(i);
        base = 16'(i * CELL_W);
      end
  end
  assign off = s1.rel_x - base;

  // Stage 3: font lookup; column 5 is the inter-character gap.
  logic [34:0] glyph_sh;
  logic [4:0]  row_bits;
  logic        glyph_hit;
  assign glyph_sh  = font(s2.code) << (int'(s2.row) * 5);
  assign row_bits  = glyph_sh[34:30];
  assign glyph_hit = (s2.col < 3'd5) && (s2.row < 3'd7) && row_bits[3'd4 - s2.col];

  assign scroll_nxt = scroll_off + STEP16;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot        <= '0;
      scroll_off  <= '0;
      bcnt        <= '0;
      visible     <= 1'b1;
      vld_pipe    <= '0;
      s1          <= '0;
      s2          <= '0;
      bus.display <= 1'b0;
    end else begin
      if (bus.wr_en && ({1'b0, bus.wr_idx} < NC5))
        slot[bus.wr_idx] <= bus.wr_code;

      if (bus.frame_tick && bus.scroll_en)
        scroll_off <= (scroll_nxt >= TW16) ? scroll_nxt - TW16 : scroll_nxt;

      if (!bus.blink_en) begin
        bcnt    <= '0;
        visible <= 1'b1;
      end else if (bus.frame_tick) begin
        if (bcnt >= BLAST) begin
          bcnt    <= '0;
          visible <= ~visible;
        end else begin
          bcnt <= bcnt + 16'd1;
        end
      end

      vld_pipe  <= {vld_pipe[0], 1'b1};
      s1.in_win <= in_win;
      s1.border <= in_win & edge_hit;
      s1.rel_x  <= (sum >= TW16) ? sum - TW16 : sum;
      s1.rel_y  <= dy;

      s2.in_win <= s1.in_win;
      s2.border <= s1.border;
      s2.code   <= slot[idx];
      s2.col    <= 3'(off >> SCALE_LOG2);
      s2.row    <= 3'(s1.rel_y >> SCALE_LOG2);

      bus.display <= vld_pipe[1] & s2.in_win & ((visible & glyph_hit) | s2.border);
    end
  end
endmodule
